// File: rtl/pe_inst_seq_if.sv
// pe_inst_seq_if: config/start inputs and ALU/writeback outputs of the PE instruction sequencer.
// Carries loop_cnt only when PE_INST_LOOP_EN is defined.
interface pe_inst_seq_if #(parameter int IWIDTH = 32, parameter int AWIDTH = 8);
    logic              cfg_we;
    logic [AWIDTH-1:0] cfg_addr;
    logic [IWIDTH-1:0] cfg_data;
    logic              start;
    logic [AWIDTH:0]   inst_num;
`ifdef PE_INST_LOOP_EN
    logic [7:0]        loop_cnt;
`endif
    logic              busy;
    logic              done;
    logic [3:0]        opcode;
    logic [3:0]        src0_sel;
    logic [3:0]        src1_sel;
    logic [3:0]        src2_sel;
    logic              wb_we;
    logic [7:0]        wb_addr;
    modport master (
        output cfg_we, cfg_addr, cfg_data, start, inst_num,
`ifdef PE_INST_LOOP_EN
        loop_cnt,
`endif
        input busy, done, opcode, src0_sel, src1_sel, src2_sel, wb_we, wb_addr
    );
    modport slave (
        input cfg_we, cfg_addr, cfg_data, start, inst_num,
`ifdef PE_INST_LOOP_EN
        loop_cnt,
`endif
        output busy, done, opcode, src0_sel, src1_sel, src2_sel, wb_we, wb_addr
    );
endinterface

// File: rtl/pe_inst_seq.sv
// pe_inst_seq: per-PE instruction sequencer replaying N stored instructions into the ALU.
// Define PE_INST_LOOP_EN to repeat the sequence loop_cnt+1 times back-to-back.
module pe_inst_seq #(
    parameter int IWIDTH   = 32,
    parameter int AWIDTH   = 8,
    parameter int WB_DELAY = 2
) (
    input logic          clk,
    input logic          rst_n,
    pe_inst_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [7:0] wa;
        logic       we;
    } inst_t;
    typedef struct packed {
        logic       we;
        logic [7:0] addr;
    } wb_t;
    state_t          state, state_nx;
    logic [AWIDTH:0] pc, pc_nx, n, n_nx;
    logic            done, done_nx, issue, go, last, unused_cfg;
    inst_t           mem [2**AWIDTH];
    inst_t           ir;
    wb_t             dl [WB_DELAY];
`ifdef PE_INST_LOOP_EN
    logic [7:0]      loops, loops_nx;
`endif
    // a Start in the Done cycle is ignored
    assign go = bus.start && !done;
    assign last = pc == n - 1'b1;
    assign unused_cfg = ^bus.cfg_data;
    always_ff @(posedge clk) begin
        if (bus.cfg_we && state == IDLE && !bus.start) mem[bus.cfg_addr] <= bus.cfg_data[31:7];
        ir <= mem[pc[AWIDTH-1:0]];
    end
    always_comb begin
        state_nx = state;
        pc_nx = pc;
        n_nx = n;
        done_nx = 1'b0;
`ifdef PE_INST_LOOP_EN
        loops_nx = loops;
`endif
        if (state == IDLE) begin
            if (go) begin
                n_nx = bus.inst_num;
                pc_nx = '0;
                state_nx = bus.inst_num != '0 ? RUN : IDLE;
                done_nx = bus.inst_num == '0;
`ifdef PE_INST_LOOP_EN
                loops_nx = bus.loop_cnt;
`endif
            end
        end else if (state == RUN) begin
            pc_nx = pc + 1'b1;
            if (last) begin
                pc_nx = '0;
`ifdef PE_INST_LOOP_EN
                loops_nx = loops - 8'd1;
                state_nx = loops == 8'd0 ? DRAIN : RUN;
`else
                state_nx = DRAIN;
`endif
            end
        end else begin
            // pc doubles as the drain counter: WB_DELAY+1 cycles until the last writeback leaves
            pc_nx = pc + 1'b1;
            if (pc == (AWIDTH+1)'(WB_DELAY)) begin
                state_nx = IDLE;
                done_nx = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= '0;
            n <= '0;
            done <= 1'b0;
            issue <= 1'b0;
`ifdef PE_INST_LOOP_EN
            loops <= '0;
`endif
            for (int i = 0; i < WB_DELAY; i++) dl[i] <= '0;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            n <= n_nx;
            done <= done_nx;
            issue <= state == RUN;
`ifdef PE_INST_LOOP_EN
            loops <= loops_nx;
`endif
            dl[0] <= '{we: issue & ir.we, addr: issue ? ir.wa : 8'h0};
            for (int i = 1; i < WB_DELAY; i++) dl[i] <= dl[i-1];
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = done;
    assign bus.opcode = issue ? ir.op : 4'h0;
    assign bus.src0_sel = issue ? ir.s0 : 4'h0;
    assign bus.src1_sel = issue ? ir.s1 : 4'h0;
    assign bus.src2_sel = issue ? ir.s2 : 4'h0;
    assign bus.wb_we = dl[WB_DELAY-1].we;
    assign bus.wb_addr = dl[WB_DELAY-1].addr;
endmodule

// File: tb/tb_pe_inst_seq.sv
// tb_pe_inst_seq: directed runs of pe_inst_seq checked cycle by cycle against a queued expectation.
module tb_pe_inst_seq;
    localparam int AW = 8;
    localparam int IW = 32;
    localparam int D = 2;
    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] op;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       we;
        logic [7:0] wa;
    } obs_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [31:0] mem [2**AW];
    obs_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    pe_inst_seq_if #(.IWIDTH(IW), .AWIDTH(AW)) bus();
    pe_inst_seq #(.IWIDTH(IW), .AWIDTH(AW), .WB_DELAY(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic chk(input string tag, input obs_t e, input bit strict);
        obs_t o;
        o = '{busy: bus.busy, done: bus.done, op: bus.opcode, s0: bus.src0_sel, s1: bus.src1_sel,
              s2: bus.src2_sel, we: bus.wb_we, wa: bus.wb_addr};
        if (!strict) o.wa = e.wa;
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask
    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_data = d;
        mem[a] = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask
    // inj_c: drive Start+Cfg_We during cycle t+inj_c; rst_c: assert reset during cycle t+rst_c
    task automatic run(input int n, input int lc, input int inj_c, input int rst_c, input string tag);
        int tot;
        int last;
        obs_t e;
        logic [31:0] w;
        bit slot;
        tot = n * (lc + 1);
        last = n > 0 ? tot + D + 5 : 4;
        for (int c = 1; c <= last; c++) begin
            e = '0;
            if (n > 0) begin
                e.busy = c <= 1 + tot + D;
                e.done = c == 2 + tot + D;
                if (c >= 2 && c < 2 + tot) begin
                    w = mem[(c - 2) % n];
                    e.op = w[31:28];
                    e.s0 = w[27:24];
                    e.s1 = w[23:20];
                    e.s2 = w[19:16];
                end
                if (c >= 2 + D && c < 2 + D + tot) begin
                    w = mem[(c - 2 - D) % n];
                    e.we = w[7];
                    e.wa = w[15:8];
                end
            end else e.done = c == 1;
            q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.inst_num = (AW+1)'(n);
`ifdef PE_INST_LOOP_EN
        bus.loop_cnt = 8'(lc);
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.inst_num = '0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            slot = n > 0 && c >= 2 + D && c < 2 + D + tot;
            e = q.pop_front();
            chk($sformatf("%s c%0d", tag, c), e, slot);
            bus.start = c == inj_c;
            bus.cfg_we = c == inj_c;
            if (c == inj_c) begin
                bus.inst_num = (AW+1)'(1);
                bus.cfg_addr = '0;
                bus.cfg_data = 32'hEEEE_EE80;
            end
            if (c == rst_c) begin
                #1 rst_n = 1'b0;
                #1 chk($sformatf("%s async_rst", tag), '0, 1'b1);
                repeat (3) begin
                    @(negedge clk);
                    chk($sformatf("%s in_rst", tag), '0, 1'b1);
                end
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk($sformatf("%s post_rst", tag), '0, 1'b1);
                end
                q.delete();
                break;
            end
        end
    endtask
    initial begin
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.start = 1'b0;
        bus.inst_num = '0;
`ifdef PE_INST_LOOP_EN
        bus.loop_cnt = '0;
`endif
        #2 rst_n = 1'b0;
        #1 chk("reset", '0, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 2**AW; a++) wr(a, $urandom);
        wr(0, 32'h1123_0580);
        wr(1, 32'h7450_0900);
        run(2, 0, 0, 0, "two_inst");
        wr(2, 32'h9ABC_3380);
        wr(3, 32'hF00F_FF00);
        run(4, 0, 0, 0, "wb_off");
        run(0, 0, 0, 0, "zero_num");
        run(4, 0, 2, 0, "start_busy");
        run(4, 0, 0, 0, "readback1");
        run(4, 0, 2 + 4 + D, 0, "start_done");
        run(4, 0, 0, 0, "readback2");
        wr(4, 32'h5678_1280);
        run(5, 0, 0, 3, "mid_reset");
        run(5, 0, 0, 0, "after_reset");
        run(2**AW, 0, 0, 0, "full_mem");
        run(1, 0, 0, 0, "one_inst");
`ifdef PE_INST_LOOP_EN
        wr(0, 32'h1111_1180);
        wr(1, 32'h2222_2200);
        wr(2, 32'h3333_3380);
        run(3, 1, 0, 0, "loop");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
